// File: rtl/softmax_seq_if.sv
// softmax_seq_if: bundles every softmax_seq signal other than clk/rst.
//   slave  : the sequencer side (softmax_seq itself)
//   master : the environment (vector source, exp unit, normaliser)
// Signal groups:
//   control : start, len, busy, err_len, clamp_seen
//   input   : in_valid, in_ready, in_x
//   exp unit: exp_x (operand out), exp_res (result in)
//   output  : out_valid, out_ready, out_idx, out_exp, out_last
//   sum     : sum, sum_valid
// Handshake rule for in_* and out_*: a transfer happens on a rising edge
// where valid and ready are both high. A producer holding valid high keeps
// its payload stable until that transfer, and ready may be low for any
// number of cycles.
interface softmax_seq_if #(
   parameter int N_MAX = 16,
   parameter int AW    = $clog2(N_MAX),
   parameter int SUM_W = 32 + AW
);
   logic             start;
   logic [AW:0]      len;
   logic             in_valid;
   logic             in_ready;
   logic [16:0]      in_x;
   logic [16:0]      exp_x;
   logic [20:0]      exp_res;
   logic             out_valid;
   logic             out_ready;
   logic [AW-1:0]    out_idx;
   logic [20:0]      out_exp;
   logic             out_last;
   logic [SUM_W-1:0] sum;
   logic             sum_valid;
   logic             busy;
   logic             err_len;
   logic             clamp_seen;

   modport slave (
      input  start, len, in_valid, in_x, exp_res, out_ready,
      output in_ready, exp_x, out_valid, out_idx, out_exp, out_last,
             sum, sum_valid, busy, err_len, clamp_seen
   );

   modport master (
      output start, len, in_valid, in_x, exp_res, out_ready,
      input  in_ready, exp_x, out_valid, out_idx, out_exp, out_last,
             sum, sum_valid, busy, err_len, clamp_seen
   );
endinterface

// File: rtl/softmax_seq.sv
// softmax_seq: buffers a softmax vector, clamps each element to the exp
// unit's +/-10 range, issues one element per cycle to a shared exp unit,
// accumulates sum(man << pos) and streams the results out with indices.
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   bus         : softmax_seq_if.slave (control, input, exp unit, output, sum)
//   dbg_state_o : current controller state (0 IDLE, 1 LOAD, 2 EXP, 3 DRAIN)
module softmax_seq #(
   parameter int N_MAX   = 16,
   parameter int AW      = $clog2(N_MAX),
   parameter int EXP_LAT = 0,
   parameter int SUM_W   = 32 + AW
) (
   input  logic        clk,
   input  logic        rst,
   softmax_seq_if.slave bus,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_EXP   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [AW:0]      len_q, len_d;
   logic [AW:0]      wr_idx_q, wr_idx_d;
   logic [AW:0]      iss_idx_q, iss_idx_d;
   logic [AW:0]      cap_cnt_q, cap_cnt_d;
   logic [AW-1:0]    rd_idx_q, rd_idx_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             sum_valid_q, sum_valid_d;
   logic             clamp_seen_q, clamp_seen_d;
   logic             err_len_q, err_len_d;
   logic [16:0]      exp_hold_q, exp_hold_d;

   logic [16:0]      buf_q [N_MAX];
   logic [20:0]      res_q [N_MAX];

   logic             len_ok, in_hs, out_hs, issue_v, cap_v, last_w, in_clip;
   logic [AW-1:0]    cap_idx;
   logic [AW:0]      len_m1;
   logic [16:0]      in_store, exp_x_w;
   logic [4:0]       pos_sat;
   logic [SUM_W-1:0] term;

   assign len_ok  = (bus.len != '0) && (bus.len <= (AW+1)'(N_MAX));
   assign len_m1  = len_q - (AW+1)'(1);
   assign in_hs   = (state_q == S_LOAD) && bus.in_valid;
   assign out_hs  = (state_q == S_DRAIN) && bus.out_ready;
   assign issue_v = (state_q == S_EXP) && (iss_idx_q < len_q);
   assign last_w  = ((AW+1)'(rd_idx_q) == len_m1);

   // exp_x follows the buffer only while issuing; otherwise the last
   // operand is held so the exp unit input does not toggle needlessly.
   assign exp_x_w = issue_v ? buf_q[iss_idx_q[AW-1:0]] : exp_hold_q;

   // Clamp out-of-range magnitudes; fold negative zero onto +0.
   always_comb begin
      in_clip  = (bus.in_x[15:12] > 4'd10);
      in_store = bus.in_x;
      if (in_clip)
         in_store = {bus.in_x[16], 4'd10, 12'd0};
      else if (bus.in_x == 17'h10000)
         in_store = '0;
   end

   // Linearised exp term; pos above 16 saturates so a term fits in 32 bits.
   assign pos_sat = (bus.exp_res[20:16] > 5'd16) ? 5'd16 : bus.exp_res[20:16];
   assign term    = SUM_W'(bus.exp_res[15:0]) << pos_sat;

   // Delay line pairing each issued index with the exp result EXP_LAT later.
   generate
      if (EXP_LAT == 0) begin : g_comb
         assign cap_v   = issue_v;
         assign cap_idx = iss_idx_q[AW-1:0];
      end else begin : g_pipe
         logic [EXP_LAT-1:0] dl_v_q;
         logic [AW-1:0]      dl_idx_q [EXP_LAT];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dl_v_q <= '0;
               for (int i = 0; i < EXP_LAT; i++) dl_idx_q[i] <= '0;
            end else begin
               dl_v_q[0]   <= issue_v;
               dl_idx_q[0] <= iss_idx_q[AW-1:0];
               for (int i = 1; i < EXP_LAT; i++) begin
                  dl_v_q[i]   <= dl_v_q[i-1];
                  dl_idx_q[i] <= dl_idx_q[i-1];
               end
            end
         end

         assign cap_v   = dl_v_q[EXP_LAT-1] && (state_q == S_EXP);
         assign cap_idx = dl_idx_q[EXP_LAT-1];
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      wr_idx_d     = wr_idx_q;
      iss_idx_d    = iss_idx_q;
      cap_cnt_d    = cap_cnt_q;
      rd_idx_d     = rd_idx_q;
      sum_d        = sum_q;
      sum_valid_d  = sum_valid_q;
      clamp_seen_d = clamp_seen_q;
      err_len_d    = 1'b0;
      exp_hold_d   = exp_x_w;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (len_ok) begin
                  len_d        = bus.len;
                  wr_idx_d     = '0;
                  iss_idx_d    = '0;
                  cap_cnt_d    = '0;
                  rd_idx_d     = '0;
                  sum_d        = '0;
                  sum_valid_d  = 1'b0;
                  clamp_seen_d = 1'b0;
                  state_d      = S_LOAD;
               end else begin
                  err_len_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (in_hs) begin
               wr_idx_d = wr_idx_q + (AW+1)'(1);
               if (in_clip) clamp_seen_d = 1'b1;
               if (wr_idx_q == len_m1) state_d = S_EXP;
            end
         end
         S_EXP: begin
            if (issue_v) iss_idx_d = iss_idx_q + (AW+1)'(1);
            if (cap_v) begin
               sum_d     = sum_q + term;
               cap_cnt_d = cap_cnt_q + (AW+1)'(1);
               if (cap_cnt_q == len_m1) begin
                  state_d     = S_DRAIN;
                  sum_valid_d = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (out_hs) begin
               rd_idx_d = rd_idx_q + AW'(1);
               if (last_w) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         wr_idx_q     <= '0;
         iss_idx_q    <= '0;
         cap_cnt_q    <= '0;
         rd_idx_q     <= '0;
         sum_q        <= '0;
         sum_valid_q  <= 1'b0;
         clamp_seen_q <= 1'b0;
         err_len_q    <= 1'b0;
         exp_hold_q   <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         wr_idx_q     <= wr_idx_d;
         iss_idx_q    <= iss_idx_d;
         cap_cnt_q    <= cap_cnt_d;
         rd_idx_q     <= rd_idx_d;
         sum_q        <= sum_d;
         sum_valid_q  <= sum_valid_d;
         clamp_seen_q <= clamp_seen_d;
         err_len_q    <= err_len_d;
         exp_hold_q   <= exp_hold_d;
      end
   end

   // Storage arrays carry no reset; every entry read is written first.
   always_ff @(posedge clk) begin
      if (in_hs) buf_q[wr_idx_q[AW-1:0]] <= in_store;
      if (cap_v) res_q[cap_idx] <= bus.exp_res;
   end

   assign bus.in_ready   = (state_q == S_LOAD);
   assign bus.exp_x      = exp_x_w;
   assign bus.out_valid  = (state_q == S_DRAIN);
   assign bus.out_idx    = (state_q == S_DRAIN) ? rd_idx_q : '0;
   assign bus.out_exp    = (state_q == S_DRAIN) ? res_q[rd_idx_q] : '0;
   assign bus.out_last   = (state_q == S_DRAIN) && last_w;
   assign bus.sum        = sum_q;
   assign bus.sum_valid  = sum_valid_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.err_len    = err_len_q;
   assign bus.clamp_seen = clamp_seen_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_softmax_seq.sv
// tb_softmax_seq: directed and randomized checks of softmax_seq with a
// pipelined exp-unit stub (latency EXP_LAT) and a behavioural model that
// derives stored operands, results and the expected sum from the input
// vector alone.
module tb_softmax_seq;
   localparam int N_MAX   = 16;
   localparam int AW      = 4;
   localparam int EXP_LAT = 3;
   localparam int SUM_W   = 32 + AW;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  dbg_state;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          stub_mode = 0;
   logic [20:0] stub_const = '0;
   logic [16:0] vec [N_MAX];
   logic [20:0] exp_q [$];
   logic [16:0] stored_q [$];
   logic [16:0] xd [EXP_LAT];

   softmax_seq_if #(.N_MAX(N_MAX), .AW(AW), .SUM_W(SUM_W)) bus ();

   softmax_seq #(.N_MAX(N_MAX), .AW(AW), .EXP_LAT(EXP_LAT), .SUM_W(SUM_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // exp-unit stub: mode 0 operand-dependent, 1 constant, 2 {0, operand[15:0]}
   function automatic logic [20:0] stub_res(input logic [16:0] x, input int mode,
                                             input logic [20:0] c);
      if (mode == 0) return {x[16], x[15:12], x[15:0] ^ 16'h5A3C};
      if (mode == 1) return c;
      return {5'd0, x[15:0]};
   endfunction

   always @(posedge clk) begin
      xd[0] <= bus.exp_x;
      for (int i = 1; i < EXP_LAT; i++) xd[i] <= xd[i-1];
   end
   always_comb bus.exp_res = stub_res(xd[EXP_LAT-1], stub_mode, stub_const);

   // reference: value the sequencer should store for an input element
   function automatic logic [16:0] ref_store(input logic [16:0] x, output bit clipped);
      int mag;
      mag = int'(x[15:12]);
      clipped = (mag > 10);
      if (clipped) return {x[16], 4'd10, 12'd0};
      if (x == 17'h10000) return 17'h0;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_rst(input string p);
      chk({p, "_in_ready"},   64'(bus.in_ready),   64'(0));
      chk({p, "_exp_x"},      64'(bus.exp_x),      64'(0));
      chk({p, "_out_valid"},  64'(bus.out_valid),  64'(0));
      chk({p, "_out_idx"},    64'(bus.out_idx),    64'(0));
      chk({p, "_out_exp"},    64'(bus.out_exp),    64'(0));
      chk({p, "_out_last"},   64'(bus.out_last),   64'(0));
      chk({p, "_sum"},        64'(bus.sum),        64'(0));
      chk({p, "_sum_valid"},  64'(bus.sum_valid),  64'(0));
      chk({p, "_busy"},       64'(bus.busy),       64'(0));
      chk({p, "_err_len"},    64'(bus.err_len),    64'(0));
      chk({p, "_clamp_seen"}, 64'(bus.clamp_seen), 64'(0));
      chk({p, "_state"},      64'(dbg_state),      64'(0));
   endtask

   // driver: one full vector from start to return to IDLE
   task automatic run_vec(input int n, input bit stall_in, input bit stall_out, input bit poke);
      logic [63:0] exp_sum;
      bit          exp_clamp, clip, have_prev, rdy;
      logic [16:0] s;
      logic [20:0] r, e, p_exp;
      logic [AW-1:0] p_idx;
      logic        p_last;
      int          pos, t0, k, beats, guard;

      exp_q.delete();
      stored_q.delete();
      exp_sum   = '0;
      exp_clamp = 0;
      for (int i = 0; i < n; i++) begin
         s = ref_store(vec[i], clip);
         exp_clamp = exp_clamp | clip;
         stored_q.push_back(s);
         r = stub_res(s, stub_mode, stub_const);
         exp_q.push_back(r);
         pos = int'(r[20:16]);
         if (pos > 16) pos = 16;
         exp_sum = exp_sum + 64'(r[15:0]) * (64'd1 << pos);
      end

      bus.start = 1'b1;
      bus.len   = (AW+1)'(n);
      t0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      chk("in_ready_after_start", 64'(bus.in_ready), 64'(1));
      chk("busy_after_start", 64'(bus.busy), 64'(1));
      chk("sum_cleared", 64'(bus.sum), 64'(0));
      chk("sum_valid_cleared", 64'(bus.sum_valid), 64'(0));
      chk("clamp_cleared", 64'(bus.clamp_seen), 64'(0));

      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b0;
         if (stall_in) repeat ($urandom_range(0, 2)) @(negedge clk);
         if (poke && i == 1) begin
            bus.start = 1'b1;
            bus.len   = '0;
            @(negedge clk);
            bus.start = 1'b0;
            chk("no_err_len_when_busy", 64'(bus.err_len), 64'(0));
         end
         chk("in_ready_load", 64'(bus.in_ready), 64'(1));
         bus.in_valid = 1'b1;
         bus.in_x     = vec[i];
         @(negedge clk);
      end
      // junk offered outside LOAD must be ignored
      bus.in_valid = 1'b1;
      bus.in_x     = 17'($urandom);

      k = 0;
      while (bus.out_valid !== 1'b1 && k < n + EXP_LAT + 20) begin
         chk("exp_x", 64'(bus.exp_x), 64'((k < n) ? stored_q[k] : stored_q[n-1]));
         chk("in_ready_exp", 64'(bus.in_ready), 64'(0));
         k++;
         @(negedge clk);
      end
      chk("exp_cycles", 64'(k), 64'(n + EXP_LAT));
      chk("sum_valid_drain", 64'(bus.sum_valid), 64'(1));
      chk("sum_drain", 64'(bus.sum), exp_sum);

      beats = 0;
      guard = 0;
      have_prev = 0;
      while (beats < n && guard < 20 * N_MAX) begin
         chk("out_valid", 64'(bus.out_valid), 64'(1));
         if (have_prev) begin
            chk("stable_idx", 64'(bus.out_idx), 64'(p_idx));
            chk("stable_exp", 64'(bus.out_exp), 64'(p_exp));
            chk("stable_last", 64'(bus.out_last), 64'(p_last));
         end
         rdy = stall_out ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.out_ready = rdy;
         if (rdy) begin
            e = exp_q.pop_front();
            chk("out_idx", 64'(bus.out_idx), 64'(beats));
            chk("out_exp", 64'(bus.out_exp), 64'(e));
            chk("out_last", 64'(bus.out_last), 64'(beats == n - 1));
            beats++;
            have_prev = 0;
         end else begin
            have_prev = 1;
            p_idx  = bus.out_idx;
            p_exp  = bus.out_exp;
            p_last = bus.out_last;
         end
         @(negedge clk);
         guard++;
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("beat_count", 64'(beats), 64'(n));
      chk("busy_end", 64'(bus.busy), 64'(0));
      chk("out_valid_end", 64'(bus.out_valid), 64'(0));
      chk("sum_end", 64'(bus.sum), exp_sum);
      chk("sum_valid_end", 64'(bus.sum_valid), 64'(1));
      chk("clamp_seen_end", 64'(bus.clamp_seen), 64'(exp_clamp));
      if (!stall_in && !stall_out && !poke)
         chk("start_to_idle", 64'(cyc - t0), 64'(1 + 3 * n + EXP_LAT));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.len = '0;
      bus.in_valid = 1'b0;
      bus.in_x = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_rst("reset");
      rst = 1'b0;
      @(negedge clk);

      // basic length-4 run with constant stub
      stub_mode  = 1;
      stub_const = {5'd16, 16'h8000};
      for (int i = 0; i < 4; i++) vec[i] = 17'(i) << 12;
      run_vec(4, 0, 0, 0);
      chk("basic_sum", 64'(bus.sum), 64'h2_0000_0000);

      // clamp of +15 and -12.5, then a clean vector clears clamp_seen
      stub_mode = 0;
      vec[0] = 17'h0F000;
      vec[1] = 17'h1C800;
      run_vec(2, 0, 0, 0);
      chk("clamp_seen_set", 64'(bus.clamp_seen), 64'(1));
      for (int i = 0; i < 3; i++)
         vec[i] = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)), 12'($urandom)};
      run_vec(3, 1, 1, 0);
      chk("clamp_seen_clean", 64'(bus.clamp_seen), 64'(0));

      // rejected lengths
      for (int b = 0; b < 2; b++) begin
         bus.start = 1'b1;
         bus.len   = (b == 0) ? (AW+1)'(0) : (AW+1)'(17);
         @(negedge clk);
         bus.start = 1'b0;
         chk("err_len_pulse", 64'(bus.err_len), 64'(1));
         chk("err_len_busy", 64'(bus.busy), 64'(0));
         @(negedge clk);
         chk("err_len_one_cycle", 64'(bus.err_len), 64'(0));
      end

      // start while busy is ignored
      for (int i = 0; i < 5; i++) vec[i] = 17'($urandom);
      run_vec(5, 0, 0, 1);

      // latency and backpressure, full-length vector
      stub_mode = 2;
      for (int i = 0; i < 16; i++) vec[i] = 17'(i);
      run_vec(16, 0, 1, 0);
      chk("lat_sum", 64'(bus.sum), 64'(120));

      // full-length vector at full rate
      stub_mode = 0;
      for (int i = 0; i < 16; i++) vec[i] = 17'($urandom);
      run_vec(16, 0, 0, 0);

      // random vectors with stalls on both sides
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++) vec[i] = 17'($urandom);
         if (r == 1) vec[0] = 17'h10000;
         run_vec(n, 1, 1, 0);
      end

      // reset in the middle of EXP, then a fresh short vector
      for (int i = 0; i < 8; i++) vec[i] = 17'($urandom);
      bus.start = 1'b1;
      bus.len   = (AW+1)'(8);
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_x     = vec[i];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_rst("midrst");
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) vec[i] = 17'($urandom);
      run_vec(2, 0, 0, 0);

      // single element with pos saturation
      stub_mode  = 1;
      stub_const = {5'd20, 16'hFFFF};
      vec[0] = 17'h03800;
      run_vec(1, 0, 0, 0);
      chk("single_sum", 64'(bus.sum), 64'h0_FFFF_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/softmax_seq.md
# softmax_seq

Sequencer that shares one exp unit (17-bit signed-magnitude input, 21-bit `{position, mantissa}` output) across a softmax input vector of up to N_MAX elements. It buffers the vector, clamps each element to the exp unit's ±10 input range, and issues one element per cycle to the exp unit. It then accumulates the linearised exp results into a sum and streams the results out with their indices, so downstream logic can normalise them. It sits between the vector source and the normaliser/divider, and owns the exp unit's input bus.

## Interface

Parameters:

- N_MAX, 16, maximum vector length; power of two, ≥2.
- AW, $clog2(N_MAX), index width.
- EXP_LAT, 0, exp-unit latency in cycles. 0 means combinational. Legal range 0–3.
- SUM_W, 32+AW, accumulator width.

Ports:

- clk  in  1  clock; all flops rise-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new vector; sampled in IDLE only.
- len  in  AW+1  vector length, sampled with start. Legal range 1..N_MAX.
- in_valid  in  1  input element valid.
- in_ready  out  1  asserted in LOAD only.
- in_x  in  17  element. Bit 16 is the sign, bits 15:12 the integer magnitude, bits 11:0 the fraction.
- exp_x  out  17  operand driven to the exp unit.
- exp_res  in  21  exp-unit result; bits 20:16 are pos, bits 15:0 are man.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_idx  out  AW  element index of the current result.
- out_exp  out  21  exp_res captured for out_idx.
- out_last  out  1  high with the final element.
- sum  out  SUM_W  Σ (man << pos) over the vector.
- sum_valid  out  1  sum is final; held until the next accepted start.
- busy  out  1  state ≠ IDLE.
- err_len  out  1  one-cycle pulse when start is rejected.
- clamp_seen  out  1  sticky per vector: some element was clamped. Cleared on an accepted start.

## Operation

The controller has four states: IDLE → LOAD → EXP → DRAIN → IDLE.

**IDLE**
- in_ready=0, out_valid=0.
- start with 1≤len≤N_MAX:
  - latch len;
  - clear sum, sum_valid, clamp_seen and the counters;
  - go to LOAD.
- start with len=0 or len>N_MAX: pulse err_len, stay in IDLE.

**LOAD**
- in_ready=1. Each in_valid&in_ready handshake writes buf[wr_idx] and increments wr_idx.
- Clamp on write: if in_x[15:12] > 10, store {in_x[16], 4'd10, 12'd0} and set clamp_seen. Otherwise store in_x unchanged.
- Negative zero (17'h10000) is stored as +0.
- After the len-th handshake, go to EXP with iss_idx=0.

**EXP**
- Each cycle with iss_idx<len:
  - exp_x = buf[iss_idx];
  - push {valid, iss_idx} into an EXP_LAT-deep delay line;
  - iss_idx++.
- A valid delay-line output with index i writes res[i]=exp_res and adds (man << pos) to sum, zero-extended to SUM_W.
- pos values above 16 are saturated to 16 before the shift.
- Go to DRAIN when all len results have been captured.
- exp_x holds its last value outside EXP. It resets to 0.

**DRAIN**
- out_valid=1. out_idx=rd_idx, out_exp=res[rd_idx], out_last=(rd_idx==len-1).
- sum_valid=1 from DRAIN entry onward.
- out_valid&out_ready increments rd_idx. The handshake with out_last set returns the block to IDLE.
- out_* must be stable while out_valid && !out_ready.

**Width rule**
- Each term is ≤ 2^32−1 and there are ≤ N_MAX terms, so sum never overflows SUM_W. No wrap handling is needed.

**Boundary conditions**
- start while busy is ignored: no err_len, no state effect.
- len=1 passes through every state with a single element; out_last is high on the only beat.
- len=N_MAX fills the buffer exactly; wr_idx is compared against len, not allowed to wrap.
- in_valid outside LOAD is ignored.
- rst mid-operation: immediate return to IDLE. Counters, sum, sum_valid, clamp_seen, flags and out_* are all cleared. Buffer contents need not be cleared.

## Timing

- Reset values: in_ready=0, exp_x=0, out_valid=0, out_idx=0, out_exp=0, out_last=0, sum=0, sum_valid=0, busy=0, err_len=0, clamp_seen=0.
- The start cycle in IDLE moves to LOAD on the next edge; in_ready rises 1 cycle after start.
- LOAD takes len handshake cycles; stalls on in_valid=0 are unbounded.
- EXP takes exactly len+EXP_LAT cycles. Issue is one per cycle with no bubbles.
- Capture happens on the edge that ends cycle (issue cycle + EXP_LAT). With EXP_LAT=0, exp_res is sampled in the same cycle exp_x is driven.
- DRAIN takes len cycles at full out_ready.
- Minimum start→IDLE is 1 + 3·len + EXP_LAT cycles.
- err_len is high for exactly the cycle after the rejected start edge.

## Test plan

- **Basic length-4 run:** EXP_LAT=0. Exp stub returns {5'd16, 16'h8000} for every operand; len=4, inputs 0,1,2,3 (integer part). Required: out_idx 0..3, out_exp=21'h108000 on each beat, sum=36'h2_0000_0000, out_last only on idx 3, busy low 13 cycles after start.
- **Clamp:** in_x=17'h0F000 (+15) and 17'h1C800 (−12.5). Required: exp_x shows 17'h0A000 and 17'h1A000; clamp_seen=1; a following clean vector clears it.
- **Length error:** start with len=0, then with len=17. Required: err_len pulses once each, busy stays 0; start while busy produces no err_len.
- **Latency and backpressure:** EXP_LAT=3, len=16, stub returns {5'd0, index}. Required: sum=120; EXP lasts 19 cycles; random out_ready stalls keep out_* stable and deliver all 16 beats in order.
- **Reset mid-operation:** assert rst in the middle of EXP. Required: next cycle all outputs are at reset values; a subsequent len=2 run completes correctly with sum from the new data only.
- **Single element:** len=1 with stub {5'd20, 16'hFFFF}. Required: pos saturates to 16, sum=36'h0_FFFF_0000, out_last on the first beat.
